// File: rtl/lt24_touch_pkg.sv
// Shared constants for the LT24 touch-ADC sampler: ADC commands, frame layout
// and FSM state codes.
package lt24_touch_pkg;

    // ADS7843 control bytes: start, channel, 12-bit, differential, PD=00
    localparam logic [7:0] CMD_X = 8'hD0;
    localparam logic [7:0] CMD_Y = 8'h90;

    // Frame layout counted in DCLK rising edges (1-based)
    localparam logic [4:0] FRAME_DCLKS     = 5'd24;
    localparam logic [4:0] CMD_BITS        = 5'd8;
    localparam logic [4:0] DATA_FIRST_EDGE = 5'd10;
    localparam int unsigned DATA_BITS      = 12;
    localparam logic [4:0] DATA_LAST_EDGE  = DATA_FIRST_EDGE + 5'(DATA_BITS - 1);

    // FSM state codes
    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StDebounce = 3'd1;
    localparam logic [2:0] StConv     = 3'd2;
    localparam logic [2:0] StPublish  = 3'd3;
    localparam logic [2:0] StGap      = 3'd4;

endpackage

// File: rtl/lt24_touch_spi_xfer.sv
// One 24-DCLK SPI frame to the touch ADC: CS framing, DCLK divider, command
// shift-out and 12-bit result shift-in. Pulses done when CS returns high.
module lt24_touch_spi_xfer
    import lt24_touch_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           cmd,
    input  logic                 dout_sync,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] data,
    output logic                 cs_n,
    output logic                 dclk,
    output logic                 din
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // Half-periods: 0 = lead-in, 2k-1/2k = low/high of edge k, 49 = tail
    localparam logic [5:0] HALF_LAST = {FRAME_DCLKS, 1'b1};

    logic                 active_q;
    logic [DIV_W-1:0]     div_q;
    logic [5:0]           half_q;
    logic [7:0]           cmd_q;
    logic [DATA_BITS-1:0] shift_q;

    logic [5:0] half_nx;
    logic [4:0] edge_nx;
    logic [4:0] edge_cur;
    logic       dclk_nx;
    logic       din_nx;
    logic       sample_now;

    assign busy = active_q;
    assign data = shift_q;

    // Decode the upcoming half-period into DCLK level, DIN bit and sample strobe
    always_comb begin
        half_nx  = half_q + 6'd1;
        edge_nx  = half_nx[5:1] + {4'd0, half_nx[0]};
        edge_cur = half_q[5:1];
        dclk_nx  = !half_nx[0] && (half_nx < HALF_LAST);
        din_nx   = din;
        // DIN only moves at the start of a low half, i.e. after DCLK falls
        if (half_nx[0]) begin
            din_nx = (edge_nx <= CMD_BITS) ? cmd_q[3'(CMD_BITS - edge_nx)] : 1'b0;
        end
        // Sample at the end of the high half: the 2-FF synchroniser delays DOUT by
        // two clk, and the ADC holds it until the next falling edge.
        sample_now = !half_q[0] && (edge_cur >= DATA_FIRST_EDGE)
                     && (edge_cur <= DATA_LAST_EDGE);
    end

    // Frame sequencer: divider, half-period counter and shift registers
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            div_q    <= '0;
            half_q   <= '0;
            cmd_q    <= '0;
            shift_q  <= '0;
            cs_n     <= 1'b1;
            dclk     <= 1'b0;
            din      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active_q) begin
                if (start) begin
                    active_q <= 1'b1;
                    cs_n     <= 1'b0;
                    div_q    <= '0;
                    half_q   <= '0;
                    cmd_q    <= cmd;
                end
            end else if (div_q == DIV_LAST) begin
                div_q <= '0;
                if (sample_now) begin
                    shift_q <= {shift_q[DATA_BITS-2:0], dout_sync};
                end
                if (half_q == HALF_LAST) begin
                    active_q <= 1'b0;
                    cs_n     <= 1'b1;
                    done     <= 1'b1;
                end else begin
                    half_q <= half_nx;
                    dclk   <= dclk_nx;
                    din    <= din_nx;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/lt24_touch_sampler.sv
// LT24 resistive-touch front end: debounces pen IRQ, runs alternating X/Y
// conversions, box-car averages them and offers one point per valid/ready.
module lt24_touch_sampler
    import lt24_touch_pkg::*;
#(
    parameter int unsigned CLK_DIV         = 25,
    parameter int unsigned AVG_LOG2        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned GAP_CYCLES      = 5000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 adc_penirq_n,
    input  logic                 adc_dout,
    output logic                 adc_din,
    output logic                 adc_dclk,
    output logic                 adc_cs_n,
    output logic [DATA_BITS-1:0] sample_x,
    output logic [DATA_BITS-1:0] sample_y,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 pen_down,
    output logic                 overrun
);

    localparam int unsigned ACC_W = DATA_BITS + AVG_LOG2;
    localparam int unsigned FRM_W = AVG_LOG2 + 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    // X and Y frames interleave, so a point takes 2 * 2^AVG_LOG2 frames
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'((2 << AVG_LOG2) - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic penirq_meta, penirq_s;
    logic dout_meta, dout_s;

    logic [2:0]       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [FRM_W-1:0] frame_cnt;
    logic [ACC_W-1:0] acc_x, acc_y;

    logic                 xfer_start, xfer_busy, xfer_done;
    logic [DATA_BITS-1:0] xfer_data;
    logic                 enter_conv;
    logic                 publish;

    // Two-flop synchronisers for the asynchronous ADC outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            penirq_meta <= 1'b1;
            penirq_s    <= 1'b1;
            dout_meta   <= 1'b0;
            dout_s      <= 1'b0;
        end else begin
            penirq_meta <= adc_penirq_n;
            penirq_s    <= penirq_meta;
            dout_meta   <= adc_dout;
            dout_s      <= dout_meta;
        end
    end

    // Next-state logic; pen IRQ is only looked at outside conversions
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!penirq_s) state_d = StDebounce;
            StDebounce: begin
                if (penirq_s)                  state_d = StIdle;
                else if (deb_cnt == DEB_LAST)  state_d = StConv;
            end
            StConv:     if (xfer_done && (frame_cnt == FRM_LAST)) state_d = StPublish;
            StPublish:  state_d = StGap;
            StGap:      if (gap_cnt == GAP_LAST) state_d = penirq_s ? StIdle : StConv;
            default:    state_d = StIdle;
        endcase
    end

    assign enter_conv = (state_d == StConv) && (state_q != StConv);
    assign publish    = (state_q == StPublish);
    // Do not restart in the done cycle itself: that frame is still being accumulated
    assign xfer_start = (state_q == StConv) && !xfer_busy && !xfer_done;

    // State register and debounce / gap timers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            deb_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state_q <= state_d;
            deb_cnt <= (state_q == StDebounce) ? deb_cnt + DEB_W'(1) : '0;
            gap_cnt <= (state_q == StGap) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

    // Per-axis accumulators; frame_cnt[0] selects the axis (0 = X)
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_x     <= '0;
            acc_y     <= '0;
            frame_cnt <= '0;
        end else if (enter_conv) begin
            acc_x     <= '0;
            acc_y     <= '0;
            frame_cnt <= '0;
        end else if ((state_q == StConv) && xfer_done) begin
            if (frame_cnt[0]) acc_y <= acc_y + ACC_W'(xfer_data);
            else              acc_x <= acc_x + ACC_W'(xfer_data);
            frame_cnt <= frame_cnt + FRM_W'(1);
        end
    end

    // Debounced touch state
    always_ff @(posedge clk) begin
        if (reset) begin
            pen_down <= 1'b0;
        end else if ((state_q == StDebounce) && (state_d == StConv)) begin
            pen_down <= 1'b1;
        end else if ((state_q == StGap) && (state_d == StIdle)) begin
            pen_down <= 1'b0;
        end
    end

    // Output register and valid/ready handshake; a publish wins over a transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_x     <= '0;
            sample_y     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (publish) begin
                sample_x     <= acc_x[ACC_W-1:AVG_LOG2];
                sample_y     <= acc_y[ACC_W-1:AVG_LOG2];
                sample_valid <= 1'b1;
                overrun      <= sample_valid && !sample_ready;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

    lt24_touch_spi_xfer #(
        .CLK_DIV (CLK_DIV)
    ) u_xfer (
        .clk       (clk),
        .reset     (reset),
        .start     (xfer_start),
        .cmd       (frame_cnt[0] ? CMD_Y : CMD_X),
        .dout_sync (dout_s),
        .busy      (xfer_busy),
        .done      (xfer_done),
        .data      (xfer_data),
        .cs_n      (adc_cs_n),
        .dclk      (adc_dclk),
        .din       (adc_din)
    );

endmodule

// File: tb/tb_lt24_touch_sampler.sv
// Bench for lt24_touch_sampler with a behavioural ADS7843 model and a
// reference averager computed from queued conversion values.
module tb_lt24_touch_sampler;

    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned DEB      = 20;
    localparam int unsigned GAP      = 10;
    localparam int NAVG      = 1 << AVG_LOG2;
    localparam int FRAME_CLK = 50 * CLK_DIV;
    localparam int TIMEOUT   = 3000;

    typedef logic [NAVG-1:0][11:0] pt_t;
    typedef struct packed {
        pt_t         xs;
        pt_t         ys;
        logic [11:0] ex;
        logic [11:0] ey;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        adc_penirq_n;
    logic        adc_dout = 1'b0;
    logic        adc_din, adc_dclk, adc_cs_n;
    logic [11:0] sample_x, sample_y;
    logic        sample_valid, sample_ready, pen_down, overrun;

    int checks = 0;
    int errors = 0;

    lt24_touch_sampler #(
        .CLK_DIV         (CLK_DIV),
        .AVG_LOG2        (AVG_LOG2),
        .DEBOUNCE_CYCLES (DEB),
        .GAP_CYCLES      (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .adc_penirq_n (adc_penirq_n),
        .adc_dout     (adc_dout),
        .adc_din      (adc_din),
        .adc_dclk     (adc_dclk),
        .adc_cs_n     (adc_cs_n),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pen_down     (pen_down),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- ADS7843 behavioural model ----------------
    logic [11:0] x_q[$];
    logic [11:0] y_q[$];
    logic [7:0]  frame_cmd[$];
    int          frame_len[$];
    int          edges = 0;
    int          cs_len = 0;
    int          cs_falls = 0;
    int          din_late = 0;
    logic [7:0]  cmd_sh = '0;
    logic [11:0] cur_val = '0;
    logic        prev_cs = 1'b1;
    logic        prev_dclk = 1'b0;

    always @(negedge clk) begin
        if (!adc_cs_n) begin
            if (prev_cs) begin
                edges = 0;
                cmd_sh = '0;
                cs_len = 0;
                cs_falls++;
            end
            cs_len++;
            if (adc_dclk && !prev_dclk) begin
                edges++;
                if (edges <= 8) cmd_sh = {cmd_sh[6:0], adc_din};
                else if (adc_din) din_late++;
                if (edges == 8) begin
                    if (cmd_sh == 8'hD0)      cur_val = (x_q.size() > 0) ? x_q.pop_front() : 12'h0;
                    else if (cmd_sh == 8'h90) cur_val = (y_q.size() > 0) ? y_q.pop_front() : 12'h0;
                    else                      cur_val = 12'h0;
                end
            end else if (!adc_dclk && prev_dclk) begin
                // Present the bit for the next rising edge after DCLK falls
                if (edges + 1 >= 10 && edges + 1 <= 21) adc_dout = cur_val[20 - edges];
                else                                    adc_dout = 1'b0;
            end
        end else if (!prev_cs) begin
            frame_cmd.push_back(cmd_sh);
            frame_len.push_back(cs_len);
        end
        prev_cs   = adc_cs_n;
        prev_dclk = adc_dclk;
    end

    // Handshake monitors, sampled before the edge updates outputs
    int ovr_cnt = 0;
    int xfer_cnt = 0;
    always @(posedge clk) begin
        if (overrun) ovr_cnt++;
        if (sample_valid && sample_ready) xfer_cnt++;
    end

    // ---------------- reference model and helpers ----------------
    function automatic logic [11:0] ref_avg(input pt_t v);
        int s = 0;
        for (int i = 0; i < NAVG; i++) s += int'(v[i]);
        return 12'(s / NAVG);
    endfunction

    task automatic push_point(input pt_t xs, input pt_t ys);
        for (int i = 0; i < NAVG; i++) begin
            x_q.push_back(xs[i]);
            y_q.push_back(ys[i]);
        end
    endtask

    function automatic pt_t rand_pt();
        pt_t p;
        for (int i = 0; i < NAVG; i++) p[i] = 12'($urandom_range(0, 4095));
        return p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_valid(input string name, output bit ok);
        int n = 0;
        while (sample_valid !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        ok = (sample_valid === 1'b1);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: sample_valid still 0 after %0d cycles", name, n);
        end
    endtask

    task automatic wait_cs_low(input string name);
        int n = 0;
        while (adc_cs_n !== 1'b0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(adc_cs_n), 0);
    endtask

    // ---------------- stimulus ----------------
    vec_t        vecs[4];
    pt_t         rx[4], ry[4];
    pt_t         ax, ay, bx, by, lx, ly;
    bit          ok;
    int          base_ovr, base_xfer, base_falls, bad_len, vcount, n;

    initial begin
        vecs[0].xs = {12'd105, 12'd102, 12'd101, 12'd100};
        vecs[0].ys = {12'd2000, 12'd2000, 12'd2000, 12'd2000};
        vecs[0].ex = 12'd102;
        vecs[0].ey = 12'd2000;
        vecs[1].xs = {12'hABC, 12'hABC, 12'hABC, 12'hABC};
        vecs[1].ys = {12'hFFF, 12'h789, 12'h456, 12'h123};
        vecs[1].ex = 12'hABC;
        vecs[1].ey = 12'd1856;
        vecs[2].xs = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        vecs[2].ys = {12'h000, 12'h000, 12'h000, 12'h000};
        vecs[2].ex = 12'hFFF;
        vecs[2].ey = 12'h000;
        vecs[3].xs = {12'd0, 12'd2, 12'd1, 12'd0};
        vecs[3].ys = {12'd6, 12'd7, 12'd7, 12'd7};
        vecs[3].ex = 12'd0;
        vecs[3].ey = 12'd6;

        reset = 1'b1;
        adc_penirq_n = 1'b1;
        sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_cs_n", int'(adc_cs_n), 1);
        chk("rst_dclk", int'(adc_dclk), 0);
        chk("rst_din", int'(adc_din), 0);
        chk("rst_sample_x", int'(sample_x), 0);
        chk("rst_sample_y", int'(sample_y), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_pen_down", int'(pen_down), 0);
        chk("rst_overrun", int'(overrun), 0);

        // Short IRQ glitch must not start sampling
        adc_penirq_n = 1'b0;
        repeat (10) @(negedge clk);
        adc_penirq_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_cs_falls", cs_falls, 0);
        chk("glitch_pen_down", int'(pen_down), 0);

        // Queue every conversion value for the continuous-touch phases
        for (int i = 0; i < 4; i++) push_point(vecs[i].xs, vecs[i].ys);
        for (int p = 0; p < 4; p++) begin
            rx[p] = rand_pt();
            ry[p] = rand_pt();
            push_point(rx[p], ry[p]);
        end
        ax = rand_pt(); ay = rand_pt();
        bx = rand_pt(); by = rand_pt();
        push_point(ax, ay);
        push_point(bx, by);

        adc_penirq_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wait_valid($sformatf("vec%0d_valid", i), ok);
            if (ok) begin
                chk($sformatf("vec%0d_x", i), int'(sample_x), int'(vecs[i].ex));
                chk($sformatf("vec%0d_y", i), int'(sample_y), int'(vecs[i].ey));
                chk($sformatf("vec%0d_pen_down", i), int'(pen_down), 1);
            end
        end

        // Frame shape: command bytes, CS-low length, quiet DIN after command
        chk("frame_count", int'(frame_cmd.size() >= 2), 1);
        if (frame_cmd.size() >= 2) begin
            chk("frame0_cmd", int'(frame_cmd[0]), 'hD0);
            chk("frame1_cmd", int'(frame_cmd[1]), 'h90);
            chk("frame0_len", frame_len[0], FRAME_CLK);
        end
        bad_len = 0;
        foreach (frame_len[i]) if (frame_len[i] != FRAME_CLK) bad_len++;
        chk("frame_len_all", bad_len, 0);
        chk("din_after_cmd", din_late, 0);

        // Randomised points against the reference averager
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            wait_valid($sformatf("rand%0d_valid", p), ok);
            if (ok) begin
                chk($sformatf("rand%0d_x", p), int'(sample_x), int'(ref_avg(rx[p])));
                chk($sformatf("rand%0d_y", p), int'(sample_y), int'(ref_avg(ry[p])));
            end
        end
        @(negedge clk);
        sample_ready = 1'b0;

        // Overrun: hold ready low across two points
        base_ovr  = ovr_cnt;
        base_xfer = xfer_cnt;
        @(negedge clk);
        wait_valid("ovr_a_valid", ok);
        chk("ovr_a_x", int'(sample_x), int'(ref_avg(ax)));
        chk("ovr_a_y", int'(sample_y), int'(ref_avg(ay)));
        n = 0;
        while (overrun !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        adc_penirq_n = 1'b1;
        chk("ovr_pulse_seen", int'(overrun), 1);
        chk("ovr_b_x", int'(sample_x), int'(ref_avg(bx)));
        chk("ovr_b_y", int'(sample_y), int'(ref_avg(by)));
        repeat (5) @(negedge clk);
        chk("ovr_once", ovr_cnt - base_ovr, 1);
        chk("ovr_hold_valid", int'(sample_valid), 1);
        chk("ovr_hold_x", int'(sample_x), int'(ref_avg(bx)));
        sample_ready = 1'b1;
        @(negedge clk);
        chk("ovr_valid_drop", int'(sample_valid), 0);
        repeat (40) @(negedge clk);
        chk("ovr_one_transfer", xfer_cnt - base_xfer, 1);
        chk("ovr_pen_up", int'(pen_down), 0);

        // Pen lifts mid-conversion: point still completes, then back to idle
        lx = rand_pt();
        ly = rand_pt();
        push_point(lx, ly);
        base_falls = cs_falls;
        adc_penirq_n = 1'b0;
        wait_cs_low("lift_cs_fall");
        repeat (20) @(negedge clk);
        adc_penirq_n = 1'b1;
        wait_valid("lift_valid", ok);
        chk("lift_x", int'(sample_x), int'(ref_avg(lx)));
        chk("lift_y", int'(sample_y), int'(ref_avg(ly)));
        chk("lift_pen_down_at_pub", int'(pen_down), 1);
        repeat (40) @(negedge clk);
        chk("lift_pen_up", int'(pen_down), 0);
        chk("lift_frames", cs_falls - base_falls, 2 * NAVG);
        repeat (200) @(negedge clk);
        chk("lift_idle_frames", cs_falls - base_falls, 2 * NAVG);
        chk("lift_idle_cs", int'(adc_cs_n), 1);

        // Reset while CS is low aborts the frame without publishing
        adc_penirq_n = 1'b0;
        wait_cs_low("rstmid_cs_fall");
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_cs_n", int'(adc_cs_n), 1);
        chk("rstmid_dclk", int'(adc_dclk), 0);
        chk("rstmid_din", int'(adc_din), 0);
        chk("rstmid_valid", int'(sample_valid), 0);
        chk("rstmid_pen_down", int'(pen_down), 0);
        adc_penirq_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sample_valid) vcount++;
        end
        chk("rstmid_no_publish", vcount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
